// File: rtl/rvj1_wb_sram_bridge.sv
// Wishbone classic slave driving port 0 (rw) of one OpenRAM 32x512 1rw1r macro.
// Decodes the window, drives the macro's active-low strobes and byte mask, waits out read latency.
module rvj1_wb_sram_bridge #(
    parameter int unsigned ADDR_WIDTH_WORDS = 9,
    parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
    parameter int unsigned SRAM_LATENCY     = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic [31:0]                 wbs_dat_o,
    output logic                        sram_clk0,
    output logic                        sram_csb0,
    output logic                        sram_web0,
    output logic [3:0]                  sram_wmask0,
    output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0,
    output logic [31:0]                 sram_din0,
    input  logic [31:0]                 sram_dout0
);

    localparam int unsigned TAG_LSB = ADDR_WIDTH_WORDS + 2;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RWAIT,
        S_RCAP,
        S_ACK,
        S_ERR
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ack_q;
    logic               err_q;
    logic [31:0]        dat_q;

    logic accept_c;
    logic hit_c;
    logic wr_access_c;
    logic rd_access_c;

    // Macro strobes are only ever asserted in the accept cycle, and never during reset.
    assign accept_c    = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign hit_c       = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) && (wbs_adr_i[1:0] == 2'b00);
    assign wr_access_c = accept_c && hit_c && wbs_we_i && (wbs_sel_i != 4'b0000);
    assign rd_access_c = accept_c && hit_c && !wbs_we_i;

    assign sram_clk0   = clk_i;
    assign sram_csb0   = !(rstn_i && (wr_access_c || rd_access_c));
    assign sram_web0   = !(rstn_i && wr_access_c);
    assign sram_wmask0 = wr_access_c ? wbs_sel_i : 4'b0000;
    assign sram_addr0  = wbs_adr_i[TAG_LSB-1:2];
    assign sram_din0   = wbs_dat_i;

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = dat_q;

    // Single-process FSM; ack/err are one-cycle registered pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        if (!hit_c) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (wbs_we_i) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end else if (SRAM_LATENCY <= 1) begin
                            state_q <= S_RCAP;
                        end else begin
                            state_q <= S_RWAIT;
                            cnt_q   <= CNT_W'(SRAM_LATENCY - 1);
                        end
                    end
                end
                S_RWAIT: begin
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_RCAP;
                        end
                    end
                end
                S_RCAP: begin
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        dat_q   <= sram_dout0;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK:   state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvj1_wb_sram_bridge.sv
// Bench for rvj1_wb_sram_bridge: two bridges (latency 1 and 3) each on a behavioural macro,
// read data scoreboarded against a reference memory image.
module tb_rvj1_wb_sram_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cyc_r = 1'b0;
    logic        stb_r = 1'b0;
    logic        we_r = 1'b0;
    logic [3:0]  sel_r = 4'h0;
    logic [31:0] adr_r = 32'h0;
    logic [31:0] dat_r = 32'h0;
    int          act = 0;

    logic [1:0]  cyc;
    logic [1:0]  ack, err, csb, web, clk0;
    logic [3:0]  wmask [2];
    logic [8:0]  addr  [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic [31:0] dato  [2];

    assign cyc[0] = cyc_r && (act == 0);
    assign cyc[1] = cyc_r && (act == 1);

    int n_cmp = 0;
    int n_bad = 0;
    int csb_lows [2] = '{0, 0};
    logic [31:0] ref_mem [2][512];
    logic [31:0] sb_q [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem  [512];
        logic [31:0] pipe [LAT];

        rvj1_wb_sram_bridge #(
            .ADDR_WIDTH_WORDS(9),
            .BASE_ADDR       (BASE),
            .SRAM_LATENCY    (LAT)
        ) u_dut (
            .clk_i      (clk),
            .rstn_i     (rst_n),
            .wbs_cyc_i  (cyc[g]),
            .wbs_stb_i  (stb_r),
            .wbs_we_i   (we_r),
            .wbs_sel_i  (sel_r),
            .wbs_adr_i  (adr_r),
            .wbs_dat_i  (dat_r),
            .wbs_ack_o  (ack[g]),
            .wbs_err_o  (err[g]),
            .wbs_dat_o  (dato[g]),
            .sram_clk0  (clk0[g]),
            .sram_csb0  (csb[g]),
            .sram_web0  (web[g]),
            .sram_wmask0(wmask[g]),
            .sram_addr0 (addr[g]),
            .sram_din0  (din[g]),
            .sram_dout0 (dout[g])
        );

        // Behavioural macro: masked write, read data appears LAT cycles after the capture edge.
        always @(posedge clk) begin
            if (!csb[g]) begin
                csb_lows[g] <= csb_lows[g] + 1;
                if (!web[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[g][b]) mem[addr[g]][8*b +: 8] <= din[g][8*b +: 8];
                end else begin
                    pipe[0] <= mem[addr[g]];
                end
            end
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
        assign dout[g] = pipe[LAT-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus transfer starting at a negedge; returns at the negedge of the response cycle
    // (bus still driven when keep=1, otherwise released and one idle cycle inserted).
    task automatic xfer(input int g, input bit we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] wd, input bit exp_err, input bit held, input bit keep);
        bit          acc;
        int          n;
        int          lat_exp;
        int          lows0;
        logic [31:0] prev;
        logic [31:0] exp_rd;
        act = g; cyc_r = 1'b1; stb_r = 1'b1; we_r = we; sel_r = sel; adr_r = adr; dat_r = wd;
        if (held) begin
            #1 check("busy_no_accept_csb", 32'(csb[g]), 32'd1);
            @(negedge clk);
        end
        prev  = dato[g];
        lows0 = csb_lows[g];
        acc   = !exp_err && (!we || sel != 4'h0);
        #1;
        check("accept_csb", 32'(csb[g]), 32'(!acc));
        check("accept_web", 32'(web[g]), 32'(!(acc && we)));
        if (acc) begin
            check("accept_addr", 32'(addr[g]), 32'(adr[10:2]));
            check("accept_wmask", 32'(wmask[g]), we ? 32'(sel) : 32'd0);
        end
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[g][adr[10:2]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                sb_q.push_back(ref_mem[g][adr[10:2]]);
            end
        end
        lat_exp = (exp_err || we) ? 1 : ((g == 0) ? 2 : 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack[g] || err[g]) && n < 10);
        check("latency", 32'(n), 32'(lat_exp));
        check("ack", 32'(ack[g]), 32'(!exp_err));
        check("err", 32'(err[g]), 32'(exp_err));
        check("csb_accesses", 32'(csb_lows[g] - lows0), acc ? 32'd1 : 32'd0);
        if (exp_err) check("err_dat_hold", dato[g], prev);
        if (!exp_err && !we) begin
            exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
            check("rdata", dato[g], exp_rd);
        end
        if (!keep) begin
            cyc_r = 1'b0; stb_r = 1'b0;
            @(negedge clk);
            check("pulse_one_cycle", 32'(ack[g] | err[g]), 32'd0);
        end
    endtask

    // Read dropped by the master one cycle after accept.
    task automatic abort_read(input int g, input logic [31:0] adr);
        logic [31:0] prev;
        prev = dato[g];
        act = g; cyc_r = 1'b1; stb_r = 1'b1; we_r = 1'b0; sel_r = 4'hF; adr_r = adr;
        @(negedge clk);
        cyc_r = 1'b0; stb_r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_ack", 32'(ack[g] | err[g]), 32'd0);
        end
        check("abort_dat_hold", dato[g], prev);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_ack", 32'(ack[g]), 32'd0);
            check("rst_err", 32'(err[g]), 32'd0);
            check("rst_dat", dato[g], 32'd0);
            check("rst_csb", 32'(csb[g]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // latency 1: full word, byte lane, empty-select write
        xfer(0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        xfer(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0,        1'b0, 1'b0, 1'b0);
        xfer(0, 1'b1, 4'h1, BASE + 32'h10, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
        xfer(0, 1'b0, 4'h1, BASE + 32'h10, 32'h0,        1'b0, 1'b0, 1'b0);
        xfer(0, 1'b1, 4'h0, BASE + 32'h10, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        xfer(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0,        1'b0, 1'b0, 1'b0);

        // decode errors
        xfer(0, 1'b0, 4'hF, BASE + 32'h800, 32'h0,       1'b1, 1'b0, 1'b0);
        xfer(0, 1'b0, 4'hF, BASE + 32'h12,  32'h0,       1'b1, 1'b0, 1'b0);
        xfer(0, 1'b1, 4'hF, 32'h2000_0010,  32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0);
        xfer(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0,        1'b0, 1'b0, 1'b0);

        // back-to-back with stb held across ack / err
        xfer(0, 1'b1, 4'hF, BASE + 32'h7FC, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        xfer(0, 1'b0, 4'hF, BASE + 32'h7FC, 32'h0,         1'b0, 1'b1, 1'b1);
        xfer(0, 1'b0, 4'hF, BASE + 32'h7FE, 32'h0,         1'b1, 1'b1, 1'b1);
        xfer(0, 1'b0, 4'hF, BASE + 32'h10,  32'h0,         1'b0, 1'b1, 1'b0);

        // latency 3: boundary words, held stb
        xfer(1, 1'b1, 4'hF, BASE + 32'h0,   32'h1111_1111, 1'b0, 1'b0, 1'b0);
        xfer(1, 1'b1, 4'hF, BASE + 32'h7FC, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1);
        xfer(1, 1'b0, 4'hF, BASE + 32'h0,   32'h0,         1'b0, 1'b1, 1'b1);
        xfer(1, 1'b0, 4'hF, BASE + 32'h7FC, 32'h0,         1'b0, 1'b1, 1'b0);

        // master abort in RWAIT (latency 3) and RCAP (latency 1)
        abort_read(1, BASE + 32'h0);
        xfer(1, 1'b0, 4'hF, BASE + 32'h0,  32'h0, 1'b0, 1'b0, 1'b0);
        abort_read(0, BASE + 32'h7FC);
        xfer(0, 1'b0, 4'h2, BASE + 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);

        // reset during RWAIT with the request still on the bus
        act = 1; cyc_r = 1'b1; stb_r = 1'b1; we_r = 1'b0; sel_r = 4'hF; adr_r = BASE + 32'h7FC;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_csb", 32'(csb[1]), 32'd1);
        check("midrst_web", 32'(web[1]), 32'd1);
        check("midrst_ack", 32'(ack[1] | err[1]), 32'd0);
        check("midrst_dat", dato[1], 32'd0);
        @(negedge clk);
        check("midrst_csb_held", 32'(csb[1]), 32'd1);
        cyc_r = 1'b0; stb_r = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_idle", 32'(ack[1] | err[1]), 32'd0);
        end
        xfer(1, 1'b1, 4'hC, BASE + 32'h7FC, 32'h9876_0000, 1'b0, 1'b0, 1'b0);
        xfer(1, 1'b0, 4'hF, BASE + 32'h7FC, 32'h0,         1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
